fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have the parameter PC_RESET, default `PC_RESET from head.v (32'h0000_0000), meaning the first fetch address after reset.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- stall  in  1  from the hazard detection unit; holds the IF/ID register and the PC.
- branch_taken  in  1  from the ID stage; redirects fetch, ignored while stall=1.
- branch_target  in  32  redirect address, valid with branch_taken.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction (0 means bubble).
- if_id_rs  out  5  if_id_instr[25:21]; feeds the hazard unit.
- if_id_rt  out  5  if_id_instr[20:16]; feeds the hazard unit.

Function
REQ-003 The FSM SHALL have three states:
- S_START: one cycle after reset, imem_req=0.
- S_FETCH: imem_req=1.
- S_HOLD: skid buffer full, imem_req=0.
REQ-004 After reset, S_START SHALL go to S_FETCH unconditionally.
REQ-005 In S_FETCH, imem_addr SHALL equal pc and stay stable until imem_ready=1.
REQ-006 A fetch completes when imem_req && imem_ready; each completing fetch SHALL set pc<=pc+4, unless REQ-010 applies.
REQ-007 On a completed fetch with stall=0 and no redirect, IF/ID SHALL load {imem_rdata, pc+4, valid=1} in the same edge.
REQ-008 On a completed fetch with stall=1, the word and pc+4 SHALL go to the skid buffer and the FSM SHALL move to S_HOLD. IF/ID is unchanged.
REQ-009 branch_taken=1 with stall=0 in S_FETCH while imem_ready=0 SHALL latch redirect_pending=1 and the target; imem_addr is not changed.
REQ-010 A completed fetch with redirect_pending=1, or with branch_taken=1 && stall=0 in the same cycle:
- the returned word SHALL be discarded;
- pc SHALL load the target (latched target if pending, else branch_target);
- redirect_pending SHALL be cleared;
- the FSM stays in S_FETCH.
REQ-011 In S_HOLD with stall=0 and branch_taken=0, IF/ID SHALL load the buffer (valid=1) and the FSM SHALL return to S_FETCH.
REQ-012 In S_HOLD with stall=0 and branch_taken=1:
- the buffer SHALL be discarded;
- pc SHALL load branch_target;
- IF/ID valid SHALL go to 0;
- the FSM SHALL return to S_FETCH.
REQ-013 IF/ID update priority SHALL be:
- rst;
- branch_taken && !stall: valid<=0 (no delay slot);
- stall: hold all fields;
- new instruction: load;
- otherwise: valid<=0 (bubble).
REQ-014 When valid<=0 is written, if_id_instr SHALL be written 32'h0 (nop) and if_id_pc4 is don't-care.
REQ-015 stall SHALL never advance pc except through REQ-008.
REQ-016 pc arithmetic SHALL be 32-bit unsigned; wrap-around from 32'hFFFF_FFFC to 0 is silent.

Reset
REQ-017 With rst=1 at a rising edge, the following SHALL hold after that edge: pc=PC_RESET, state=S_START, redirect_pending=0, buffer empty, if_id_instr=0, if_id_pc4=0, if_id_valid=0, imem_req=0.
REQ-018 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ready is ignored.

Structure
REQ-019 PC_RESET, the state encodings and the NOP constant SHALL live in head.v.
REQ-020 The IF/ID register SHALL be the sub-module if_id_reg, with ports clk, rst, en, clr and data. The PC, FSM and skid buffer SHALL stay in fetch_stage.

Verification
REQ-021 Reset, then imem_ready=1 always, stall=0: imem_addr SHALL be 0,4,8 on consecutive cycles, and if_id_pc4 SHALL be 4,8,12 one cycle later.
REQ-022 imem_ready=0 for 3 cycles at addr 0x10: imem_addr SHALL stay 0x10 for all 4 cycles, and if_id_valid SHALL be 0 until the word loads.
REQ-023 stall=1 for 2 cycles while fetch 0x20 completes:
- IF/ID SHALL hold;
- the FSM SHALL enter S_HOLD with imem_req=0;
- the cycle after stall drops, IF/ID SHALL show pc4=0x24, then fetch resumes at 0x24.
REQ-024 branch_taken=1, target=0x100, while fetch 0x30 waits 2 cycles: the 0x30 word SHALL be discarded, the next imem_addr SHALL be 0x100, and IF/ID valid SHALL be 0.
REQ-025 branch_taken=1 in S_HOLD with stall=0, target=0x200: the buffer SHALL be dropped, the next imem_addr SHALL be 0x200, and no buffered word SHALL reach IF/ID.
REQ-026 rst pulsed while imem_req=1 with imem_ready=0: the cycle after reset imem_req SHALL be 0 and pc SHALL be PC_RESET; a stray imem_ready SHALL not change IF/ID.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] FS_PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: reset clears everything, clr inserts a bubble (nop),
// en loads a new instruction, otherwise the contents are held.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   clr,
  input  if_id_t data,
  output if_id_t q
);

  // Bubble takes precedence over load; pc4 is left untouched on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      q.instr <= NOP;
      q.pc4   <= 32'h0;
      q.valid <= 1'b0;
    end else if (clr) begin
      q.instr <= NOP;
      q.valid <= 1'b0;
    end else if (en) begin
      q <= data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry skid buffer for a stall
// that lands on a completing fetch, pending-redirect latch, and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = FS_PC_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [4:0]  if_id_rs,
  output logic [4:0]  if_id_rt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         redir_q, redir_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;

  logic         fire;
  logic         take;
  logic [31:0]  pc_plus4;
  logic         ifid_en;
  logic         ifid_clr;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_ready;
  assign take      = branch_taken && !stall;
  assign pc_plus4  = pc_q + 32'd4;

  // Next-state, PC, redirect latch, skid buffer and IF/ID load/clear decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    tgt_d        = tgt_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_en      = 1'b0;
    ifid_d.instr = imem_rdata;
    ifid_d.pc4   = pc_plus4;
    ifid_d.valid = 1'b1;
    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (fire) begin
          if (redir_q || take) begin
            // Word belongs to the wrong path: drop it and jump.
            pc_d    = redir_q ? tgt_q : branch_target;
            redir_d = 1'b0;
          end else if (stall) begin
            // IF/ID is frozen, so park the word until the stall clears.
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = S_HOLD;
          end else begin
            pc_d    = pc_plus4;
            ifid_en = 1'b1;
          end
        end else if (take) begin
          // Keep imem_addr stable for the outstanding request; redirect later.
          redir_d = 1'b1;
          tgt_d   = branch_target;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          state_d = S_FETCH;
          if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            ifid_en      = 1'b1;
            ifid_d.instr = buf_instr_q;
            ifid_d.pc4   = buf_pc4_q;
          end
        end
      end
      default: state_d = S_START;
    endcase
    ifid_clr = take || (!stall && !ifid_en);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_START;
      pc_q    <= PC_RESET;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  // Redirect target and skid-buffer payload; their validity lives in control state.
  always_ff @(posedge clk) begin
    tgt_q       <= tgt_d;
    buf_instr_q <= buf_instr_d;
    buf_pc4_q   <= buf_pc4_d;
  end

  if_id_reg u_if_id (
    .clk  (clk),
    .rst  (rst),
    .en   (ifid_en),
    .clr  (ifid_clr),
    .data (ifid_d),
    .q    (ifid_q)
  );

  assign if_id_instr = ifid_q.instr;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = ifid_q.valid;
  assign if_id_rs    = ifid_q.instr[25:21];
  assign if_id_rt    = ifid_q.instr[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_load[$];

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed fetch and every new IF/ID load is popped and compared.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc4 = 32'h0;
  logic [31:0] mon_e;
  logic [31:0] mon_w;

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ready) begin
        if (exp_fetch.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
        end else begin
          mon_e = exp_fetch.pop_front();
          chk("fetch_addr", imem_addr, mon_e);
        end
      end
      if (if_id_valid === 1'b1 && (prev_valid !== 1'b1 || if_id_pc4 !== prev_pc4)) begin
        if (exp_load.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL load_unexpected: got pc4 %h expected no load", if_id_pc4);
        end else begin
          mon_e = exp_load.pop_front();
          mon_w = word_at(mon_e - 32'd4);
          chk("load_pc4", if_id_pc4, mon_e);
          chk("load_instr", if_id_instr, mon_w);
          chk("load_rs", {27'd0, if_id_rs}, {27'd0, mon_w[25:21]});
          chk("load_rt", {27'd0, if_id_rt}, {27'd0, mon_w[20:16]});
        end
      end
    end
    prev_valid <= if_id_valid;
    prev_pc4   <= if_id_pc4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n back-to-back fetches from address a with the memory always ready.
  task automatic stream(input logic [31:0] a, input int n);
    imem_ready   = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_fetch.push_back(a + 32'(4 * i));
      exp_load.push_back(a + 32'(4 * i + 4));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    rst = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("start_no_load", {31'd0, if_id_valid}, 32'd0);

    // Straight-line fetch 0,4,8,C
    stream(32'h0, 4);

    // Memory not ready for 3 cycles at 0x10
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wait_addr", imem_addr, 32'h10);
      if (k > 0) chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
      step();
    end
    chk("wait_addr4", imem_addr, 32'h10);
    chk("wait_valid4", {31'd0, if_id_valid}, 32'd0);
    imem_ready = 1'b1;
    exp_fetch.push_back(32'h10);
    exp_load.push_back(32'h14);
    step();
    stream(32'h14, 3);

    // Stall for 2 cycles while fetch 0x20 completes
    stall = 1'b1;
    exp_fetch.push_back(32'h20);
    step();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc4", if_id_pc4, 32'h20);
    chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    chk("hold_req2", {31'd0, imem_req}, 32'd0);
    chk("hold_pc4_2", if_id_pc4, 32'h20);
    stall = 1'b0;
    exp_load.push_back(32'h24);
    step();
    chk("unhold_pc4", if_id_pc4, 32'h24);
    chk("unhold_addr", imem_addr, 32'h24);
    chk("unhold_req", {31'd0, imem_req}, 32'd1);
    stream(32'h24, 3);

    // Branch while fetch 0x30 waits 2 cycles
    imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h100;
    step();
    chk("br_addr_kept", imem_addr, 32'h30);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_instr_nop", if_id_instr, 32'h0);
    branch_taken = 1'b0;
    branch_target = 32'hDEAD_BEE0;
    step();
    chk("br_addr_kept2", imem_addr, 32'h30);
    imem_ready = 1'b1;
    exp_fetch.push_back(32'h30);
    step();
    chk("br_redirect", imem_addr, 32'h100);
    chk("br_discard", {31'd0, if_id_valid}, 32'd0);
    stream(32'h100, 2);

    // Branch in S_HOLD drops the buffered word
    stall = 1'b1;
    exp_fetch.push_back(32'h108);
    step();
    chk("hbr_req", {31'd0, imem_req}, 32'd0);
    chk("hbr_pc4", if_id_pc4, 32'h108);
    stall = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    step();
    chk("hbr_addr", imem_addr, 32'h200);
    chk("hbr_req2", {31'd0, imem_req}, 32'd1);
    chk("hbr_valid", {31'd0, if_id_valid}, 32'd0);
    stream(32'h200, 2);

    // Reset while a request is outstanding
    imem_ready = 1'b0;
    step();
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h208);
    rst = 1'b1;
    step();
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_pc", imem_addr, 32'h0);
    chk("mrst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mrst_instr", if_id_instr, 32'h0);
    rst = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("stray_valid", {31'd0, if_id_valid}, 32'd0);
    chk("stray_instr", if_id_instr, 32'h0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    stream(32'h0, 1);

    // Branch coinciding with a completing fetch, then PC wrap-around
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    exp_fetch.push_back(32'h4);
    step();
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'd0, if_id_valid}, 32'd0);
    stream(32'hFFFF_FFFC, 2);
    chk("wrap_addr", imem_addr, 32'h4);

    imem_ready = 1'b0;
    step();
    step();
    chk("fetch_q_empty", exp_fetch.size(), 32'd0);
    chk("load_q_empty", exp_load.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
